// File: rtl/bram_tdp_bist_if.sv
// Control/status and dual-port RAM bus for bram_tdp_bist.
// master = BIST controller side, slave = RAM/host side.
interface bram_tdp_bist_if #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned DATA_WIDTH    = 18,
  parameter int unsigned ERR_CNT_WIDTH = 16
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  logic [ADDR_WIDTH-1:0]    first_err_addr;
  logic                     first_err_port;
  logic [ADDR_WIDTH-1:0]    a_addr;
  logic [ADDR_WIDTH-1:0]    b_addr;
  logic                     a_wen;
  logic                     b_wen;
  logic                     a_ren;
  logic                     b_ren;
  logic [DATA_WIDTH-1:0]    a_wdata;
  logic [DATA_WIDTH-1:0]    b_wdata;
  logic [DATA_WIDTH-1:0]    a_rdata;
  logic [DATA_WIDTH-1:0]    b_rdata;

  modport master (
    input  start, a_rdata, b_rdata,
    output busy, done, pass, err_cnt, first_err_addr, first_err_port,
           a_addr, b_addr, a_wen, b_wen, a_ren, b_ren, a_wdata, b_wdata
  );

  modport slave (
    output start, a_rdata, b_rdata,
    input  busy, done, pass, err_cnt, first_err_addr, first_err_port,
           a_addr, b_addr, a_wen, b_wen, a_ren, b_ren, a_wdata, b_wdata
  );
endinterface

// File: rtl/bram_tdp_bist.sv
// Write/read-back BIST for one true-dual-port block RAM, both ports on one clock.
// Define BRAM_TDP_BIST_CROSS_CHECK_EN to add a cross-port read phase before DONE.
module bram_tdp_bist #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned DATA_WIDTH    = 18,
  parameter int unsigned RD_LATENCY    = 1,
  parameter logic [35:0] PATTERN       = 36'h055055055,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  bram_tdp_bist_if.master bus
);
  localparam int unsigned   IW         = ADDR_WIDTH - 1;
  localparam int unsigned   EW1        = ERR_CNT_WIDTH + 1;
  localparam logic [IW-1:0] DRAIN_LAST = IW'(RD_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_A_WR, S_A_RD, S_A_DRAIN, S_B_WR, S_B_RD, S_B_DRAIN,
`ifdef BRAM_TDP_BIST_CROSS_CHECK_EN
    S_X_RD, S_X_DRAIN,
`endif
    S_DONE
  } state_t;

  // Address replicated LSB-first across the data width, then scrambled.
  function automatic logic [DATA_WIDTH-1:0] f_data(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] rep;
    for (int unsigned j = 0; j < DATA_WIDTH; j++) rep[j] = addr[j % ADDR_WIDTH];
    return rep ^ PATTERN[DATA_WIDTH-1:0];
  endfunction

  state_t                   r_state;
  logic [IW-1:0]            r_idx;
  logic                     r_busy, r_done, r_pass, r_first_port;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic [ADDR_WIDTH-1:0]    r_first_addr;
  logic [ADDR_WIDTH-1:0]    r_a_addr, r_b_addr;
  logic                     r_a_wen, r_b_wen, r_a_ren, r_b_ren;
  logic [DATA_WIDTH-1:0]    r_a_wdata, r_b_wdata;
  logic [RD_LATENCY:1]      r_a_tag, r_b_tag;
  logic [ADDR_WIDTH-1:0]    r_a_paddr [1:RD_LATENCY];
  logic [ADDR_WIDTH-1:0]    r_b_paddr [1:RD_LATENCY];

  logic [IW-1:0]            w_idx_inc;
  logic                     w_last, w_drain_last, w_a_mis, w_b_mis;
  logic [EW1-1:0]           w_sum;
  logic [ERR_CNT_WIDTH-1:0] w_err_nxt;

  always_comb begin
    w_idx_inc    = r_idx + IW'(1);
    w_last       = &r_idx;
    w_drain_last = (r_idx == DRAIN_LAST);
    w_a_mis      = r_a_tag[RD_LATENCY] && (bus.a_rdata != f_data(r_a_paddr[RD_LATENCY]));
    w_b_mis      = r_b_tag[RD_LATENCY] && (bus.b_rdata != f_data(r_b_paddr[RD_LATENCY]));
    w_sum        = {1'b0, r_err_cnt} + EW1'(w_a_mis) + EW1'(w_b_mis);
    w_err_nxt    = w_sum[ERR_CNT_WIDTH] ? '1 : w_sum[ERR_CNT_WIDTH-1:0];
  end

  // Read tags and addresses travel with the RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_tag <= '0;
      r_b_tag <= '0;
      for (int unsigned k = 1; k <= RD_LATENCY; k++) begin
        r_a_paddr[k] <= '0;
        r_b_paddr[k] <= '0;
      end
    end else begin
      r_a_tag[1]   <= r_a_ren;
      r_b_tag[1]   <= r_b_ren;
      r_a_paddr[1] <= r_a_addr;
      r_b_paddr[1] <= r_b_addr;
      for (int unsigned k = 2; k <= RD_LATENCY; k++) begin
        r_a_tag[k]   <= r_a_tag[k-1];
        r_b_tag[k]   <= r_b_tag[k-1];
        r_a_paddr[k] <= r_a_paddr[k-1];
        r_b_paddr[k] <= r_b_paddr[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_first_addr <= '0;
      r_first_port <= 1'b0;
      r_a_addr     <= '0;
      r_b_addr     <= '0;
      r_a_wen      <= 1'b0;
      r_b_wen      <= 1'b0;
      r_a_ren      <= 1'b0;
      r_b_ren      <= 1'b0;
      r_a_wdata    <= '0;
      r_b_wdata    <= '0;
    end else begin
      r_err_cnt <= w_err_nxt;
      // Port A wins the first-error record on a same-cycle double mismatch.
      if (r_err_cnt == '0) begin
        if (w_a_mis) begin
          r_first_addr <= r_a_paddr[RD_LATENCY];
          r_first_port <= 1'b0;
        end else if (w_b_mis) begin
          r_first_addr <= r_b_paddr[RD_LATENCY];
          r_first_port <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE, S_DONE: if (bus.start) begin
          r_state      <= S_A_WR;
          r_busy       <= 1'b1;
          r_done       <= 1'b0;
          r_pass       <= 1'b0;
          r_err_cnt    <= '0;
          r_first_addr <= '0;
          r_first_port <= 1'b0;
          r_idx        <= '0;
          r_a_wen      <= 1'b1;
          r_a_addr     <= '0;
          r_a_wdata    <= f_data('0);
        end
        S_A_WR, S_A_RD: begin
          r_idx    <= w_idx_inc;
          r_a_addr <= {1'b0, w_idx_inc};
          if (w_last) begin
            r_state <= (r_state == S_A_WR) ? S_A_RD : S_A_DRAIN;
            r_a_wen <= 1'b0;
            r_a_ren <= (r_state == S_A_WR);
          end else if (r_state == S_A_WR) begin
            r_a_wdata <= f_data({1'b0, w_idx_inc});
          end
        end
        S_A_DRAIN: begin
          r_idx <= w_drain_last ? '0 : w_idx_inc;
          if (w_drain_last) begin
            r_state   <= S_B_WR;
            r_b_wen   <= 1'b1;
            r_b_addr  <= {1'b1, IW'(0)};
            r_b_wdata <= f_data({1'b1, IW'(0)});
          end
        end
        S_B_WR, S_B_RD: begin
          r_idx    <= w_idx_inc;
          r_b_addr <= {1'b1, w_idx_inc};
          if (w_last) begin
            r_state <= (r_state == S_B_WR) ? S_B_RD : S_B_DRAIN;
            r_b_wen <= 1'b0;
            r_b_ren <= (r_state == S_B_WR);
          end else if (r_state == S_B_WR) begin
            r_b_wdata <= f_data({1'b1, w_idx_inc});
          end
        end
`ifdef BRAM_TDP_BIST_CROSS_CHECK_EN
        S_B_DRAIN: begin
          r_idx <= w_drain_last ? '0 : w_idx_inc;
          if (w_drain_last) begin
            r_state  <= S_X_RD;
            r_a_ren  <= 1'b1;
            r_b_ren  <= 1'b1;
            r_a_addr <= {1'b1, IW'(0)};
            r_b_addr <= {1'b0, IW'(0)};
          end
        end
        // Each port reads back the half written by the other port.
        S_X_RD: begin
          r_idx    <= w_idx_inc;
          r_a_addr <= {1'b1, w_idx_inc};
          r_b_addr <= {1'b0, w_idx_inc};
          if (w_last) begin
            r_state <= S_X_DRAIN;
            r_a_ren <= 1'b0;
            r_b_ren <= 1'b0;
          end
        end
        S_X_DRAIN: begin
`else
        S_B_DRAIN: begin
`endif
          r_idx <= w_drain_last ? '0 : w_idx_inc;
          if (w_drain_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.err_cnt        = r_err_cnt;
  assign bus.first_err_addr = r_first_addr;
  assign bus.first_err_port = r_first_port;
  assign bus.a_addr         = r_a_addr;
  assign bus.b_addr         = r_b_addr;
  assign bus.a_wen          = r_a_wen;
  assign bus.b_wen          = r_b_wen;
  assign bus.a_ren          = r_a_ren;
  assign bus.b_ren          = r_b_ren;
  assign bus.a_wdata        = r_a_wdata;
  assign bus.b_wdata        = r_b_wdata;
endmodule
